camera_emulator: RTL and testbench
==================================

Name: camera_emulator

Overview:
- Transmit-side counterpart of the `camera` capture block: drives OV7670-style parallel camera signals (pclk, vsync, href/hsync, 8-bit data) from host-supplied pixels.
- Pixels arrive as 32-bit words from a standard (non-FWFT) FIFO fed by /dev/xillybus_write_32, in the packed layout `{8'd0, R5, 3'd0, G6, 2'd0, B5, 3'd0}`.
- Used for loopback testing of the capture path without a physical camera.

Parameters:
- IMG_WIDTH, 640: active pixels per line.
- IMG_HEIGHT, 480: active lines per frame.
- PCLK_DIV, 2: clk cycles per pclk half-period; must be ≥1.
- VSYNC_LINES, 3: line periods with vsync high.
- VBACK_LINES, 17: blank line periods after vsync, before the first active line.
- VFRONT_LINES, 10: blank line periods after the last active line.
- HBLANK_PCLKS, 144: pclk periods of href low after each active line.

Ports:
- clk, in, 1: bus_clk domain clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: start/continue frame generation.
- pix_rden, out, 1: FIFO read strobe.
- pix_empty, in, 1: FIFO empty.
- pix_data, in, 32: FIFO dout, valid the cycle after pix_rden.
- cam_pclk, out, 1: emulated pixel clock.
- cam_vsync, out, 1: frame sync, active high.
- cam_hsync, out, 1: href, high during active bytes.
- cam_data, out, 8: pixel byte.
- frame_count, out, 16: completed frames, wraps at 0xFFFF→0.
- underrun, out, 1: sticky; a pixel slot found no pixel held.
- busy, out, 1: state ≠ IDLE.

Behaviour:
- One clock; reset is synchronous and active-high, named reset, clocked on clk.
- Reset values:
  - All outputs 0.
  - State IDLE, divider 0, hold register empty.
  - No outstanding read.
- Reset mid-frame aborts immediately. Any prefetched pixel is discarded; FIFO contents are untouched.
- pclk generation:
  - Divider counts 0..PCLK_DIV-1 and toggles cam_pclk at terminal count.
  - It runs when enable=1 or state≠IDLE; otherwise the divider is held at 0 and pclk is low.
  - A "tick" is the clk cycle in which pclk goes 1→0.
  - All of vsync/hsync/data/state change only on ticks, so they are stable around the rising edge.
- Timing unit: line period L = 2*IMG_WIDTH + HBLANK_PCLKS pclk periods.
- FSM (transitions on ticks):
  - IDLE: if enable → VSYNC.
  - VSYNC: vsync=1, hsync=0 for VSYNC_LINES*L ticks → VBACK.
  - VBACK: all low for VBACK_LINES*L → ACTIVE (row 0).
  - ACTIVE: hsync=1 for 2*IMG_WIDTH ticks, alternating high byte then low byte of each pixel → HBLANK.
  - HBLANK: hsync=0 and data=0 for HBLANK_PCLKS ticks. Then, if row < IMG_HEIGHT-1, increment row → ACTIVE; else frame_count += 1 → VFRONT.
  - VFRONT: VFRONT_LINES*L → VSYNC if enable, else IDLE. Dropping enable mid-frame always finishes the current frame.
- Unpack: R=pix_data[23:19], G=pix_data[15:10], B=pix_data[7:3]. RGB565 = {R,G,B}. Bits 31:24, 18:16, 9:8 and 2:0 are ignored.
- Prefetch:
  - One-entry hold register; at most one read outstanding.
  - pix_rden is a 1-cycle pulse when hold is empty, !pix_empty, no read is in flight, and (enable or busy). Data is captured the next cycle.
  - Reads are never issued when pix_empty=1.
  - At the tick starting a pixel's high byte: if hold is valid, load the pixel and empty hold. A refill may start the following cycle.
  - If hold is empty at that tick: emit 0x00/0x00 for the pixel, set underrun, consume nothing. A late-arriving pixel is used for the next slot.
- Pixels are not aligned to frames: the stream is a continuous FIFO order. A pixel held after a frame is used first in the next.
- cam_data outside ACTIVE is 0x00.

Test Plan:
Common parameters: IMG_WIDTH=4, IMG_HEIGHT=2, PCLK_DIV=1, VSYNC_LINES=1, VBACK_LINES=1, VFRONT_LINES=1, HBLANK_PCLKS=2, so L=10 pclk and a frame is 50 pclk = 100 clk.
- Single frame:
  - Stimulus: preload 8 words of 0x00800400; pulse enable for one cycle.
  - Expected: vsync high for exactly 10 pclk; 10 pclk blank; two href windows of 8 pclk with 2 pclk gaps; bytes sampled at pclk rise alternate 0x80, 0x20.
  - Afterwards: frame_count=1, busy falls after VFRONT, underrun=0, exactly 8 rden pulses.
- Unpack:
  - Stimulus: word 0xFFF8FCF8 → bytes 0xFF, 0xFF; word 0x00000000 → 0x00, 0x00.
  - Expected: garbage bits 0xFF in 31:24 ignored.
- Underrun:
  - Stimulus: preload 5 words; run one frame.
  - Expected: pixels 6–8 output 0x00/0x00; underrun=1 and stays set; no rden while empty.
- Enable drop and continuous run:
  - Stimulus: hold enable high for 2 frames, drop it mid-frame 3.
  - Expected: frame 3 completes, frame_count=3, then IDLE with pclk low.
- Reset mid-ACTIVE:
  - Stimulus: assert reset for 1 cycle.
  - Expected: next cycle all outputs 0, frame_count=0, underrun=0.
  - Then re-enable: vsync is the first thing asserted.
- PCLK_DIV=3:
  - Expected: pclk period 6 clk; data/hsync change only on falling pclk; rden pulses stay single-cycle with ≥1 cycle spacing.

Source files
------------

// File: rtl/camera_emulator_if.sv
// Pixel FIFO read port and OV7670-style camera pins of the camera emulator.
interface camera_emulator_if;
  // FIFO side: pix_rden pops one word only while pix_empty is low, and
  // pix_data is valid the cycle after pix_rden. Camera side: vsync, hsync and
  // data change only as cam_pclk falls, so they are stable at its rising edge.
  logic        pix_rden;
  logic        pix_empty;
  logic [31:0] pix_data;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_hsync;
  logic [7:0]  cam_data;

  modport master (
    output pix_rden, cam_pclk, cam_vsync, cam_hsync, cam_data,
    input  pix_empty, pix_data
  );

  modport slave (
    input  pix_rden, cam_pclk, cam_vsync, cam_hsync, cam_data,
    output pix_empty, pix_data
  );
endinterface

// File: rtl/camera_emulator.sv
// OV7670-style camera transmitter: replays RGB565 pixels taken from a host FIFO
// as pclk/vsync/href/data with programmable frame timing.
module camera_emulator #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int PCLK_DIV     = 2,
  parameter int VSYNC_LINES  = 3,
  parameter int VBACK_LINES  = 17,
  parameter int VFRONT_LINES = 10,
  parameter int HBLANK_PCLKS = 144
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  camera_emulator_if.master bus,
  output logic [15:0]       frame_count,
  output logic              underrun,
  output logic              busy,
  output logic [2:0]        state_dbg
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    HBLANK = 3'd4,
    VFRONT = 3'd5
  } state_t;

  localparam int LINE_T = 2 * IMG_WIDTH + HBLANK_PCLKS;
  localparam int VS_T   = VSYNC_LINES * LINE_T;
  localparam int VB_T   = VBACK_LINES * LINE_T;
  localparam int VF_T   = VFRONT_LINES * LINE_T;
  localparam int ACT_T  = 2 * IMG_WIDTH;
  localparam int CW     = $clog2(VS_T + VB_T + VF_T + ACT_T + HBLANK_PCLKS + 1);
  localparam int DW     = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
  localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] VS_LAST  = CW'(VS_T - 1);
  localparam logic [CW-1:0] VB_LAST  = CW'(VB_T - 1);
  localparam logic [CW-1:0] VF_LAST  = CW'(VF_T - 1);
  localparam logic [CW-1:0] ACT_LAST = CW'(ACT_T - 1);
  localparam logic [CW-1:0] HB_LAST  = CW'(HBLANK_PCLKS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  state_t        state;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [RW-1:0] row;
  logic          start_req;
  logic          rd_pend;
  logic          hold_valid;
  logic [15:0]   hold_pix;
  logic [15:0]   cur_pix;
  logic          run;
  logic          tick;
  logic          pix_start;
  logic [15:0]   pix_rgb;
  logic          pix_unused;

  // Padding bits of the packed host word carry no colour information.
  assign pix_rgb    = {bus.pix_data[23:19], bus.pix_data[15:10], bus.pix_data[7:3]};
  assign pix_unused = ^{bus.pix_data[31:24], bus.pix_data[18:16],
                        bus.pix_data[9:8], bus.pix_data[2:0]};

  // start_req keeps pclk running after a one-cycle enable pulse until the
  // first tick moves the FSM out of IDLE.
  assign run       = enable | start_req | (state != IDLE);
  assign tick      = run & bus.cam_pclk & (div == DIV_LAST);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Ticks on which the next byte is a pixel's high byte.
  always_comb begin
    pix_start = 1'b0;
    case (state)
      VBACK:   pix_start = (cnt == VB_LAST);
      ACTIVE:  pix_start = cnt[0] & (cnt != ACT_LAST);
      HBLANK:  pix_start = (cnt == HB_LAST) & (row != ROW_LAST);
      default: pix_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      div           <= '0;
      cnt           <= '0;
      row           <= '0;
      start_req     <= 1'b0;
      rd_pend       <= 1'b0;
      hold_valid    <= 1'b0;
      hold_pix      <= '0;
      cur_pix       <= '0;
      frame_count   <= '0;
      underrun      <= 1'b0;
      bus.pix_rden  <= 1'b0;
      bus.cam_pclk  <= 1'b0;
      bus.cam_vsync <= 1'b0;
      bus.cam_hsync <= 1'b0;
      bus.cam_data  <= '0;
    end else begin
      // One-entry prefetch with at most one read in flight.
      bus.pix_rden <= 1'b0;
      rd_pend      <= bus.pix_rden;
      if (rd_pend) begin
        hold_valid <= 1'b1;
        hold_pix   <= pix_rgb;
      end
      if (!hold_valid && !rd_pend && !bus.pix_rden && !bus.pix_empty &&
          (enable || state != IDLE)) begin
        bus.pix_rden <= 1'b1;
      end

      if (!run) begin
        div          <= '0;
        bus.cam_pclk <= 1'b0;
      end else if (div == DIV_LAST) begin
        div          <= '0;
        bus.cam_pclk <= ~bus.cam_pclk;
      end else begin
        div <= div + DW'(1);
      end

      if (state == IDLE && enable) start_req <= 1'b1;

      if (tick) begin
        case (state)
          IDLE: begin
            state         <= VSYNC;
            bus.cam_vsync <= 1'b1;
            cnt           <= '0;
            start_req     <= 1'b0;
          end
          VSYNC: begin
            if (cnt == VS_LAST) begin
              state         <= VBACK;
              bus.cam_vsync <= 1'b0;
              cnt           <= '0;
            end else cnt <= cnt + CW'(1);
          end
          VBACK: begin
            if (cnt == VB_LAST) begin
              state         <= ACTIVE;
              bus.cam_hsync <= 1'b1;
              cnt           <= '0;
              row           <= '0;
            end else cnt <= cnt + CW'(1);
          end
          ACTIVE: begin
            if (cnt == ACT_LAST) begin
              state         <= HBLANK;
              bus.cam_hsync <= 1'b0;
              bus.cam_data  <= '0;
              cnt           <= '0;
            end else begin
              cnt <= cnt + CW'(1);
              if (!cnt[0]) bus.cam_data <= cur_pix[7:0];
            end
          end
          HBLANK: begin
            if (cnt == HB_LAST) begin
              cnt <= '0;
              if (row == ROW_LAST) begin
                state       <= VFRONT;
                frame_count <= frame_count + 16'd1;
              end else begin
                state         <= ACTIVE;
                bus.cam_hsync <= 1'b1;
                row           <= row + RW'(1);
              end
            end else cnt <= cnt + CW'(1);
          end
          VFRONT: begin
            if (cnt == VF_LAST) begin
              cnt <= '0;
              if (enable) begin
                state         <= VSYNC;
                bus.cam_vsync <= 1'b1;
              end else state <= IDLE;
            end else cnt <= cnt + CW'(1);
          end
          default: state <= IDLE;
        endcase

        // An empty hold register at a pixel slot yields a black pixel.
        if (pix_start) begin
          if (hold_valid) begin
            cur_pix      <= hold_pix;
            bus.cam_data <= hold_pix[15:8];
            hold_valid   <= 1'b0;
          end else begin
            cur_pix      <= '0;
            bus.cam_data <= '0;
            underrun     <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_camera_emulator.sv
// Directed-random bench for camera_emulator: two instances (PCLK_DIV 1 and 3)
// compared against a per-pclk frame model fed from the same pixel stream.
module tb_camera_emulator;
  localparam int W      = 4;
  localparam int H      = 2;
  localparam int HB     = 2;
  localparam int LINE_P = 2 * W + HB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        en_a, en_b;
  logic [15:0] fc_a, fc_b;
  logic        ur_a, ur_b, busy_a, busy_b;
  logic [2:0]  st_a, st_b;

  camera_emulator_if if_a ();
  camera_emulator_if if_b ();

  camera_emulator #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PCLK_DIV(1), .VSYNC_LINES(1),
    .VBACK_LINES(1), .VFRONT_LINES(1), .HBLANK_PCLKS(HB)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .bus(if_a),
    .frame_count(fc_a), .underrun(ur_a), .busy(busy_a), .state_dbg(st_a)
  );

  camera_emulator #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PCLK_DIV(3), .VSYNC_LINES(1),
    .VBACK_LINES(1), .VFRONT_LINES(1), .HBLANK_PCLKS(HB)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .bus(if_b),
    .frame_count(fc_b), .underrun(ur_b), .busy(busy_b), .state_dbg(st_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Expected per-pclk samples {vsync, hsync, data} and the model pixel streams.
  logic [9:0]  exp_a_q[$];
  logic [9:0]  exp_b_q[$];
  logic [31:0] fifo_a_q[$];
  logic [31:0] fifo_b_q[$];
  logic [31:0] pix_a_q[$];
  logic [31:0] pix_b_q[$];
  int          m_frames_a = 0, m_frames_b = 0;
  logic        m_under_a = 1'b0, m_under_b = 1'b0;
  int          rden_a_cnt = 0, rden_b_cnt = 0;

  logic        a_prev_pclk = 1'b0, b_prev_pclk = 1'b0, b_prev_rden = 1'b0;
  logic [9:0]  b_prev_sig = '0;
  int          b_last_rise = 0;
  bit          b_have_rise = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rgb565(input logic [31:0] w);
    int r, g, b;
    r = int'((w >> 19) % 32);
    g = int'((w >> 10) % 64);
    b = int'((w >> 3) % 32);
    return r * 2048 + g * 32 + b;
  endfunction

  task automatic push_word(input bit is_b, input logic [31:0] w);
    if (is_b) begin
      fifo_b_q.push_back(w);
      pix_b_q.push_back(w);
      if_b.pix_empty = 1'b0;
    end else begin
      fifo_a_q.push_back(w);
      pix_a_q.push_back(w);
      if_a.pix_empty = 1'b0;
    end
  endtask

  // One whole frame as seen at consecutive rising pclk edges.
  task automatic build_frame(input bit is_b);
    logic [9:0]  s[$];
    logic [31:0] w;
    int          rgb;
    for (int i = 0; i < LINE_P; i++) s.push_back(10'h200);
    for (int i = 0; i < LINE_P; i++) s.push_back(10'h000);
    for (int r = 0; r < H; r++) begin
      for (int p = 0; p < W; p++) begin
        rgb = 0;
        if (is_b && pix_b_q.size() > 0) begin
          w = pix_b_q.pop_front();
          rgb = rgb565(w);
        end else if (!is_b && pix_a_q.size() > 0) begin
          w = pix_a_q.pop_front();
          rgb = rgb565(w);
        end else if (is_b) m_under_b = 1'b1;
        else m_under_a = 1'b1;
        s.push_back({2'b01, 8'(rgb / 256)});
        s.push_back({2'b01, 8'(rgb % 256)});
      end
      for (int i = 0; i < HB; i++) s.push_back(10'h000);
    end
    for (int i = 0; i < LINE_P; i++) s.push_back(10'h000);
    foreach (s[i]) begin
      if (is_b) exp_b_q.push_back(s[i]);
      else exp_a_q.push_back(s[i]);
    end
    if (is_b) m_frames_b++;
    else m_frames_a++;
  endtask

  // Advance to the next falling clk edge, serve FIFO reads and check outputs.
  task automatic step();
    logic [9:0] e, sig_a, sig_b;
    @(negedge clk);
    cyc++;
    if (if_a.pix_rden) begin
      chk("a_rden_nonempty", fifo_a_q.size() > 0, 1);
      if (fifo_a_q.size() > 0) if_a.pix_data = fifo_a_q.pop_front();
      rden_a_cnt++;
    end
    if_a.pix_empty = (fifo_a_q.size() == 0);
    if (if_b.pix_rden) begin
      chk("b_rden_nonempty", fifo_b_q.size() > 0, 1);
      chk("b_rden_pulse", b_prev_rden, 0);
      if (fifo_b_q.size() > 0) if_b.pix_data = fifo_b_q.pop_front();
      rden_b_cnt++;
    end
    if_b.pix_empty = (fifo_b_q.size() == 0);
    b_prev_rden = if_b.pix_rden;

    sig_a = {if_a.cam_vsync, if_a.cam_hsync, if_a.cam_data};
    if (if_a.cam_pclk && !a_prev_pclk && busy_a) begin
      if (exp_a_q.size() == 0) chk("a_extra_sample", sig_a, 10'h3ff);
      else begin
        e = exp_a_q.pop_front();
        chk("a_sample", sig_a, e);
      end
    end
    a_prev_pclk = if_a.cam_pclk;

    sig_b = {if_b.cam_vsync, if_b.cam_hsync, if_b.cam_data};
    if (sig_b != b_prev_sig) chk("b_change_on_fall", {b_prev_pclk, if_b.cam_pclk}, 2'b10);
    if (!busy_b) b_have_rise = 1'b0;
    if (if_b.cam_pclk && !b_prev_pclk && busy_b) begin
      if (b_have_rise) chk("b_pclk_period", cyc - b_last_rise, 6);
      b_last_rise = cyc;
      b_have_rise = 1'b1;
      if (exp_b_q.size() == 0) chk("b_extra_sample", sig_b, 10'h3ff);
      else begin
        e = exp_b_q.pop_front();
        chk("b_sample", sig_b, e);
      end
    end
    b_prev_pclk = if_b.cam_pclk;
    b_prev_sig  = sig_b;
  endtask

  task automatic run_to_idle(input bit is_b, input int limit);
    for (int i = 0; i < 20; i++) begin
      if (is_b ? busy_b : busy_a) break;
      step();
    end
    chk(is_b ? "b_started" : "a_started", is_b ? busy_b : busy_a, 1);
    for (int i = 0; i < limit; i++) begin
      if (!(is_b ? busy_b : busy_a)) break;
      step();
    end
    chk(is_b ? "b_finished" : "a_finished", is_b ? busy_b : busy_a, 0);
  endtask

  task automatic pulse_a();
    en_a = 1'b1;
    step();
    en_a = 1'b0;
  endtask

  task automatic check_a_reset(input string tag);
    chk({tag, "_out"}, {if_a.cam_pclk, if_a.cam_vsync, if_a.cam_hsync,
                        if_a.cam_data, if_a.pix_rden, busy_a}, 0);
    chk({tag, "_fc"}, fc_a, 0);
    chk({tag, "_ur"}, ur_a, 0);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    if_a.pix_empty = 1'b1;
    if_a.pix_data  = '0;
    if_b.pix_empty = 1'b1;
    if_b.pix_data  = '0;
    repeat (3) step();
    check_a_reset("reset");
    chk("reset_b", {if_b.cam_pclk, if_b.cam_vsync, if_b.cam_hsync, if_b.cam_data,
                    if_b.pix_rden, busy_b, ur_b, fc_b}, 0);
    reset = 1'b0;
    step();

    // Single frame of a constant pixel.
    rden_a_cnt = 0;
    for (int i = 0; i < 8; i++) push_word(1'b0, 32'h0080_0400);
    build_frame(1'b0);
    pulse_a();
    run_to_idle(1'b0, 400);
    chk("single_len", exp_a_q.size(), 0);
    chk("single_fc", fc_a, 16'(m_frames_a));
    chk("single_ur", ur_a, m_under_a);
    chk("single_rden", rden_a_cnt, 8);
    chk("single_pclk_low", if_a.cam_pclk, 0);

    // Padding bits must not leak into the colour bytes.
    push_word(1'b0, 32'hFFF8_FCF8);
    push_word(1'b0, 32'h0000_0000);
    push_word(1'b0, 32'hFF07_0307);
    for (int i = 0; i < 5; i++) push_word(1'b0, $urandom());
    build_frame(1'b0);
    pulse_a();
    run_to_idle(1'b0, 400);
    chk("unpack_len", exp_a_q.size(), 0);
    chk("unpack_fc", fc_a, 16'(m_frames_a));
    chk("unpack_ur", ur_a, m_under_a);

    // Too few pixels for a frame.
    rden_a_cnt = 0;
    for (int i = 0; i < 5; i++) push_word(1'b0, $urandom());
    build_frame(1'b0);
    pulse_a();
    run_to_idle(1'b0, 400);
    chk("under_len", exp_a_q.size(), 0);
    chk("under_ur", ur_a, m_under_a);
    chk("under_rden", rden_a_cnt, 5);
    repeat (10) step();
    chk("under_sticky", ur_a, m_under_a);

    // Continuous run, enable dropped partway through the third frame.
    base = m_frames_a;
    for (int i = 0; i < 24; i++) push_word(1'b0, $urandom());
    for (int f = 0; f < 3; f++) build_frame(1'b0);
    en_a = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (fc_a == 16'(base + 2)) break;
      step();
    end
    chk("cont_two_frames", fc_a, 16'(base + 2));
    repeat (60) step();
    chk("cont_mid_frame3", busy_a, 1);
    en_a = 1'b0;
    run_to_idle(1'b0, 300);
    chk("cont_len", exp_a_q.size(), 0);
    chk("cont_fc", fc_a, 16'(m_frames_a));
    chk("cont_ur", ur_a, m_under_a);
    repeat (10) step();
    chk("cont_idle_pclk", if_a.cam_pclk, 0);
    chk("cont_idle_state", st_a, 0);

    // Reset while href is active, then restart from an empty FIFO.
    build_frame(1'b0);
    pulse_a();
    for (int i = 0; i < 200; i++) begin
      if (if_a.cam_hsync) break;
      step();
    end
    chk("rst_reached_active", if_a.cam_hsync, 1);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_a_reset("rst_mid");
    exp_a_q.delete();
    m_frames_a = 0;
    m_under_a  = 1'b0;
    build_frame(1'b0);
    pulse_a();
    for (int i = 0; i < 20; i++) begin
      if (if_a.cam_vsync || if_a.cam_hsync || if_a.cam_data != 8'h00) break;
      step();
    end
    chk("rst_first_vsync", {if_a.cam_vsync, if_a.cam_hsync, if_a.cam_data}, 10'h200);
    run_to_idle(1'b0, 400);
    chk("rst_len", exp_a_q.size(), 0);
    chk("rst_fc", fc_a, 16'(m_frames_a));
    chk("rst_ur", ur_a, m_under_a);

    // Slower pixel clock instance.
    for (int i = 0; i < 8; i++) push_word(1'b1, $urandom());
    build_frame(1'b1);
    en_b = 1'b1;
    step();
    en_b = 1'b0;
    run_to_idle(1'b1, 1000);
    chk("div3_len", exp_b_q.size(), 0);
    chk("div3_fc", fc_b, 16'(m_frames_b));
    chk("div3_ur", ur_b, m_under_b);
    chk("div3_rden", rden_b_cnt, 8);
    chk("div3_pclk_low", if_b.cam_pclk, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
